// File: rtl/y_demux4_router_pkg.sv
// Shared constants for the 1-to-4 demux router.
// Channel count, select width and default counter width.
package y_demux4_router_pkg;

  localparam int CH_COUNT  = 4;
  localparam int SEL_W     = 2;
  localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/y_chan_reg.sv
// One-entry valid/ready holding register with routed-word counter.
// Ports: clk, rst_n, load/in_data in; out_ready in; out_data/out_valid/out_cnt out.
module y_chan_reg #(
  parameter int SIZE  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [SIZE-1:0]  in_data,
  input  logic             out_ready,
  output logic [SIZE-1:0]  out_data,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_cnt
);

  logic drain;

  assign drain = out_valid & out_ready;

  // load wins over drain so a word can
  // replace the drained one on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= in_data;
      out_valid <= 1'b1;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

  // wraps modulo 2^CNT_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt <= '0;
    end else if (load) begin
      out_cnt <= out_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/y_demux4_router.sv
// Registered 1-to-4 demux router with per-channel valid/ready and counters.
// Ports: in_data/in_sel/in_valid/in_ready upstream; out_* flattened per channel.
module y_demux4_router
  import y_demux4_router_pkg::*;
#(
  parameter int SIZE  = 32,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SIZE-1:0]           in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [CH_COUNT*SIZE-1:0]  out_data,
  output logic [CH_COUNT-1:0]       out_valid,
  input  logic [CH_COUNT-1:0]       out_ready,
  output logic [CH_COUNT*CNT_W-1:0] out_cnt
);

  logic                sel_free;
  logic                accept;
  logic [CH_COUNT-1:0] load;

  // only the addressed channel can stall the input
  assign sel_free = ~out_valid[in_sel] | out_ready[in_sel];
  assign in_ready = rst_n & sel_free;
  assign accept   = in_valid & in_ready;

  always_comb begin
    load = '0;
    unique case (in_sel)
      2'd0: load[0] = accept;
      2'd1: load[1] = accept;
      2'd2: load[2] = accept;
      2'd3: load[3] = accept;
      default: load = '0;
    endcase
  end

  for (genvar k = 0; k < CH_COUNT; k++) begin : g_ch
    y_chan_reg #(
      .SIZE  (SIZE),
      .CNT_W (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[k]),
      .in_data   (in_data),
      .out_ready (out_ready[k]),
      .out_data  (out_data[k*SIZE +: SIZE]),
      .out_valid (out_valid[k]),
      .out_cnt   (out_cnt[k*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_y_demux4_router.sv
// Scoreboard bench for y_demux4_router.
// Per-channel queues of expected words plus a counter model.
module tb_y_demux4_router;

  logic         clk;
  logic         rst_n;
  logic [31:0]  in_data;
  logic [1:0]   in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] out_data;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [31:0]  out_cnt;

  int n_checks;
  int n_pass;
  int cyc;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] q2[$];
  logic [31:0] q3[$];
  logic [7:0]  cnt_m[4];

  y_demux4_router dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cnt   (out_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  function automatic int qsize(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic logic [31:0] qfront(input int k);
    case (k)
      0: return q0[0];
      1: return q1[0];
      2: return q2[0];
      default: return q3[0];
    endcase
  endfunction

  task automatic qpop(input int k);
    case (k)
      0: void'(q0.pop_front());
      1: void'(q1.pop_front());
      2: void'(q2.pop_front());
      default: void'(q3.pop_front());
    endcase
  endtask

  task automatic qpush(input int k, input logic [31:0] d);
    case (k)
      0: q0.push_back(d);
      1: q1.push_back(d);
      2: q2.push_back(d);
      default: q3.push_back(d);
    endcase
  endtask

  task automatic model_reset();
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
    for (int k = 0; k < 4; k++) cnt_m[k] = 8'd0;
  endtask

  // Monitor: mid-cycle, inputs and outputs are stable.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("valid%0d", k), 64'(out_valid[k]),
              64'(qsize(k) != 0));
        if (out_valid[k] && qsize(k) != 0)
          check($sformatf("data%0d", k), 64'(out_data[k*32 +: 32]),
                64'(qfront(k)));
      end
      if (in_valid)
        check("in_ready", 64'(in_ready),
              64'((qsize(int'(in_sel)) == 0) || out_ready[in_sel]));
      for (int k = 0; k < 4; k++)
        if (out_valid[k] && out_ready[k] && qsize(k) != 0) qpop(k);
      if (in_valid && in_ready) begin
        qpush(int'(in_sel), in_data);
        cnt_m[in_sel] = cnt_m[in_sel] + 8'd1;
      end
    end
  end

  ap_hold: assert property (@(posedge clk) disable iff (!rst_n)
    in_valid && !in_ready |=> in_valid && $stable(in_data) && $stable(in_sel));

  ap_sel: assert property (@(posedge clk) disable iff (!rst_n)
    in_valid |-> !$isunknown(in_sel));

  task automatic check_cnts(input string tag);
    for (int k = 0; k < 4; k++)
      check($sformatf("%s_cnt%0d", tag, k),
            64'(out_cnt[k*8 +: 8]), 64'(cnt_m[k]));
  endtask

  task automatic send(input logic [31:0] d, input logic [1:0] s);
    bit ok;
    ok = 1'b0;
    in_data  = d;
    in_sel   = s;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("send_timeout", 64'(0), 64'(1));
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int c0;
  logic [7:0] base0;

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    in_data   = 32'h0;
    in_sel    = 2'd0;
    in_valid  = 1'b1;
    out_ready = 4'b1111;
    model_reset();

    // reset with in_valid high
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_data", 64'(out_data[63:0] | out_data[127:64]), 64'(0));
    check("rst_cnt", 64'(out_cnt), 64'(0));
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    check("post_rst_ready", 64'(in_ready), 64'(1));

    // basic routing
    send(32'hDEADBEEF, 2'd2);
    check("route2_v", 64'(out_valid[2]), 64'(1));
    check("route2_d", 64'(out_data[64 +: 32]), 64'hDEADBEEF);
    send(32'h12345678, 2'd0);
    idle();
    check("route0_d", 64'(out_data[0 +: 32]), 64'h12345678);
    @(posedge clk);
    #1;
    check("route_drained", 64'(out_valid), 64'(0));
    check("route_cnt", 64'(out_cnt), 64'h00010001);
    check_cnts("route");

    // backpressure on ch1
    out_ready[1] = 1'b0;
    send(32'hA5A5A5A5, 2'd1);
    fork
      send(32'h5A5A5A5A, 2'd1);
      begin
        repeat (3) @(negedge clk);
        check("bp_stall", 64'(in_ready), 64'(0));
        check("bp_hold", 64'(out_data[32 +: 32]), 64'hA5A5A5A5);
        @(posedge clk);
        #1;
        out_ready[1] = 1'b1;
      end
    join
    idle();
    out_ready[1] = 1'b0;
    check("bp_new", 64'(out_data[32 +: 32]), 64'h5A5A5A5A);
    check("bp_cnt1", 64'(out_cnt[8 +: 8]), 64'(2));
    out_ready[1] = 1'b1;
    @(posedge clk);
    #1;

    // ch3 stalled, others stream without bubbles
    out_ready[3] = 1'b0;
    send(32'h0000FFFF, 2'd3);
    c0 = cyc;
    for (int i = 0; i < 12; i++) send(32'hC0DE0000 + 32'(i), 2'(i % 3));
    idle();
    check("indep_cycles", 64'(cyc - c0), 64'(12));
    check("indep_ch3", 64'(out_data[96 +: 32]), 64'h0000FFFF);
    check_cnts("indep");
    out_ready[3] = 1'b1;
    @(posedge clk);
    #1;

    // sustained load+drain on ch0
    base0 = cnt_m[0];
    send(32'hF0000000, 2'd0);
    c0 = cyc;
    for (int i = 1; i <= 10; i++) begin
      send(32'hF0000000 + 32'(i), 2'd0);
      check("ld_valid", 64'(out_valid[0]), 64'(1));
    end
    idle();
    check("ld_cycles", 64'(cyc - c0), 64'(10));
    check("ld_cnt", 64'(out_cnt[0 +: 8] - base0), 64'(11));
    check_cnts("ld");

    // counter wrap on ch1 from a clean reset
    do_reset();
    for (int i = 0; i < 255; i++) send(32'(i), 2'd1);
    idle();
    check("wrap_255", 64'(out_cnt[8 +: 8]), 64'(255));
    send(32'hBEEF0001, 2'd1);
    idle();
    check("wrap_0", 64'(out_cnt[8 +: 8]), 64'(0));
    check_cnts("wrap");

    // asynchronous reset between edges
    out_ready[2] = 1'b0;
    send(32'h77778888, 2'd2);
    idle();
    check("mid_v_pre", 64'(out_valid[2]), 64'(1));
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_valid", 64'(out_valid), 64'(0));
    check("mid_cnt", 64'(out_cnt), 64'(0));
    check("mid_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 4'b1111;
    send(32'h13572468, 2'd3);
    idle();
    check("resume_d", 64'(out_data[96 +: 32]), 64'h13572468);
    check_cnts("resume");
    @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
